// File: rtl/uart_pkg.sv
// uart_pkg: types, limits and helpers shared by the UART transmitter and its receive-side successor
package uart_pkg;
    localparam int MIN_DATA_W = 5;
    typedef enum logic [2:0] {NONE = 3'd0, ODD = 3'd1, EVEN = 3'd2, MARK = 3'd3, SPACE = 3'd4} parity_e;
    typedef enum logic [1:0] {STOP1 = 2'd0, STOP15 = 2'd1, STOP2 = 2'd2} stop_e;
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} tx_state_e;
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_w);
        return (len < 4'(MIN_DATA_W)) ? 4'(MIN_DATA_W) : (int'(len) > max_w) ? 4'(max_w) : len;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts baud ticks while enabled and flags the tick that closes a period of i_limit+1 ticks
module uart_bit_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_bit_end
);
    logic [CNT_W-1:0] r_cnt;
    assign o_bit_end = i_en && i_tick && (r_cnt == i_limit);
    always_ff @(posedge clk) begin
        if (rst || !i_en || o_bit_end) r_cnt <= '0;
        else if (i_tick) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_gen.sv
// uart_tx_gen: valid/ready UART transmitter with 5..MAX_DATA_W data bits, parity, 1/1.5/2 stop bits and break
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int MAX_DATA_W = 9,
    parameter int OVS        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_pulse,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [MAX_DATA_W-1:0] s_data,
    input  logic [3:0]            cfg_len,
    input  logic [2:0]            cfg_parity,
    input  logic [1:0]            cfg_stop,
    input  logic                  cfg_break,
    output logic                  busy,
    output logic                  done,
    output logic                  tx
);
    localparam int CNT_W = $clog2(2 * OVS);
    tx_state_e             r_state;
    logic [MAX_DATA_W-1:0] r_data;
    logic [3:0]            r_len;
    parity_e               r_par;
    stop_e                 r_stop;
    logic [3:0]            r_idx;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_tx;
    tx_state_e             w_state_nx;
    logic [3:0]            w_idx_nx;
    logic                  w_accept;
    logic                  w_bit_end;
    logic                  w_par_bit;
    logic                  w_frame_bit;
    logic [MAX_DATA_W-1:0] w_masked;
    logic [CNT_W-1:0]      w_limit;
    assign s_ready  = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tx       = r_tx;
    assign w_accept = s_valid && r_ready;
    // only the stop field stretches beyond one bit period
    assign w_limit = (r_state != STOP)  ? CNT_W'(OVS - 1) :
                     (r_stop == STOP2)  ? CNT_W'(2 * OVS - 1) :
                     (r_stop == STOP15) ? CNT_W'(3 * OVS / 2 - 1) : CNT_W'(OVS - 1);
    assign w_masked  = r_data & ~({MAX_DATA_W{1'b1}} << r_len);
    assign w_par_bit = (r_par == ODD) ? ~^w_masked : (r_par == EVEN) ? ^w_masked : (r_par == MARK);
    uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_state != IDLE),
        .i_tick   (baud_pulse),
        .i_limit  (w_limit),
        .o_bit_end(w_bit_end)
    );
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        case (r_state)
            IDLE: begin
                w_state_nx = w_accept ? START : IDLE;
                w_idx_nx   = w_accept ? 4'd0 : r_idx;
            end
            START:  w_state_nx = w_bit_end ? DATA : START;
            DATA: begin
                if (w_bit_end && r_idx == r_len - 4'd1) w_state_nx = (r_par == NONE) ? STOP : PARITY;
                else if (w_bit_end) w_idx_nx = r_idx + 4'd1;
            end
            PARITY: w_state_nx = w_bit_end ? STOP : PARITY;
            STOP:   w_state_nx = w_bit_end ? IDLE : STOP;
            default: w_state_nx = IDLE;
        endcase
    end
    // line level is derived from the next state so tx changes on the same edge as the FSM
    assign w_frame_bit = (w_state_nx == START)  ? 1'b0 :
                         (w_state_nx == DATA)   ? r_data[w_idx_nx] :
                         (w_state_nx == PARITY) ? w_par_bit : 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_len   <= 4'(MIN_DATA_W);
            r_par   <= NONE;
            r_stop  <= STOP1;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_ready <= (w_state_nx == IDLE);
            r_busy  <= (w_state_nx != IDLE);
            r_done  <= (r_state == STOP) && w_bit_end;
            r_tx    <= w_frame_bit & ~cfg_break;
            if (w_accept) begin
                r_data <= s_data;
                r_len  <= clamp_len(cfg_len, MAX_DATA_W);
                r_par  <= (cfg_parity > 3'd4) ? NONE : parity_e'(cfg_parity);
                r_stop <= cfg_stop[1] ? STOP2 : cfg_stop[0] ? STOP15 : STOP1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_gen.sv
// tb_uart_tx_gen: scoreboard bench; frames are expanded from their configuration into per-baud-tick line levels
module tb_uart_tx_gen;
    localparam int MW  = 9;
    localparam int OVS = 16;
    logic clk = 0, rst = 1, baud_pulse = 0, s_valid = 0, cfg_break = 0;
    logic [MW-1:0] s_data = '0;
    logic [3:0] cfg_len = 4'd8;
    logic [2:0] cfg_parity = '0;
    logic [1:0] cfg_stop = '0;
    logic s_ready, busy, done, tx;
    int n_tests = 0, n_fail = 0, cyc = 0, done_cyc = -1;
    bit baud_rand = 0, hold_chk = 0;
    typedef struct {logic [MW-1:0] data; int len; int par; int stop;} frame_t;
    frame_t sb[$];
    int exp_q[$], got_q[$];

    uart_tx_gen #(.MAX_DATA_W(MW), .OVS(OVS)) dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .cfg_len(cfg_len), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
        .cfg_break(cfg_break), .busy(busy), .done(done), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference: a frame is a list of line levels, one per baud tick while busy
    function automatic void build(input frame_t f);
        int len, ones;
        len = f.len < 5 ? 5 : (f.len > MW ? MW : f.len);
        ones = 0;
        exp_q = {};
        repeat (OVS) exp_q.push_back(0);
        for (int i = 0; i < len; i++) begin
            ones += int'(f.data[i]);
            repeat (OVS) exp_q.push_back(int'(f.data[i]));
        end
        if (f.par >= 1 && f.par <= 4)
            repeat (OVS) exp_q.push_back(f.par == 1 ? int'(ones % 2 == 0) : f.par == 2 ? ones % 2 : int'(f.par == 3));
        repeat (f.stop == 0 ? OVS : (f.stop == 1 ? OVS * 3 / 2 : 2 * OVS)) exp_q.push_back(1);
    endfunction

    initial forever begin
        @(posedge clk); #1;
        baud_pulse = baud_rand ? ($urandom_range(1) == 1) : 1'b1;
    end

    logic brk_q = 0, done_q = 0, busy_q = 0;
    always @(posedge clk) brk_q <= cfg_break;

    initial begin : monitor
        int busy_cyc, bad;
        bit all_baud;
        busy_cyc = 0;
        all_baud = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                got_q = {};
                sb = {};
                busy_cyc = 0;
                all_baud = 1;
            end else begin
                if (s_ready && busy) begin
                    n_fail++;
                    $display("FAIL ready_busy: s_ready=1 while busy=1 at cycle %0d", cyc);
                end
                if (busy && !busy_q && hold_chk && done_cyc >= 0) check("b2b_gap_le2", int'(cyc - done_cyc <= 2), 1);
                if (busy) begin
                    busy_cyc++;
                    if (!baud_pulse) all_baud = 0;
                end
                if (busy && baud_pulse) begin
                    if (brk_q) begin
                        check("break_low", int'(tx), 0);
                        got_q.push_back(2);
                    end else got_q.push_back(int'(tx));
                end
                if (done) begin
                    check("done_pulse", int'(done_q), 0);
                    done_cyc = cyc;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame: done with 0 frames outstanding, expected 1");
                    end else begin
                        build(sb.pop_front());
                        check("frame_ticks", got_q.size(), exp_q.size());
                        bad = -1;
                        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                            if (bad < 0 && got_q[i] != 2 && got_q[i] != exp_q[i]) bad = i;
                        check("frame_first_bad_tick", bad, -1);
                        if (all_baud) check("busy_cycles", busy_cyc, exp_q.size());
                    end
                    got_q = {};
                    busy_cyc = 0;
                    all_baud = 1;
                end
            end
            busy_q = busy;
            done_q = done;
        end
    end

    task automatic send(input logic [MW-1:0] d, input int len, input int par, input int stop, input bit hold);
        bit ok = 0;
        s_data = d;
        cfg_len = 4'(len);
        cfg_parity = 3'(par);
        cfg_stop = 2'(stop);
        s_valid = 1;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (s_ready) begin
                sb.push_back('{d, len, par, stop});
                ok = 1;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept: s_ready got 0, expected 1 within 3000 cycles");
        end
        s_valid = hold;
        s_data = MW'($urandom);
        cfg_len = 4'($urandom);
        cfg_parity = 3'($urandom);
        cfg_stop = 2'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && !busy;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle: outstanding frames got %0d, expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check({tag, "_tx"}, int'(tx), 1);
        check({tag, "_ready"}, int'(s_ready), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        @(negedge clk);
        check({tag, "_ready_rise"}, int'(s_ready), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        pulse_reset("rst");
        send(9'h055, 8, 0, 0, 0);
        wait_idle();
        send(9'h003, 7, 1, 2, 0);
        wait_idle();
        send(9'h1FF, 9, 2, 0, 0);
        wait_idle();
        send(9'h01F, 5, 3, 0, 0);
        wait_idle();
        done_cyc = -1;
        hold_chk = 1;
        send(MW'($urandom), 8, 0, 1, 1);
        send(MW'($urandom), 8, 2, 1, 0);
        wait_idle();
        hold_chk = 0;
        send(MW'($urandom), 8, 0, 0, 0);
        repeat (48) @(posedge clk);
        #1 cfg_break = 1;
        repeat (40) @(posedge clk);
        #1 cfg_break = 0;
        wait_idle();
        send(MW'($urandom), 8, 2, 0, 0);
        repeat (150) @(posedge clk);
        #1;
        pulse_reset("midrst");
        send(MW'($urandom), 3, 0, 0, 0);
        wait_idle();
        baud_rand = 1;
        for (int i = 0; i < 20; i++)
            send(MW'($urandom), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3),
                 i < 19 ? bit'($urandom_range(1)) : 1'b0);
        wait_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: cycles got 50000, expected fewer");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
